// File: rtl/bp_tlb_ctrl_pkg.sv
// Shared types and default widths for the bp_tlb_ctrl TLB miss/refill sequencer.
// The optional performance counters are enabled with `BP_TLB_CTRL_PERF_EN.
package bp_tlb_ctrl_pkg;

   localparam int vtag_width_gp        = 32'd27;
   localparam int paddr_width_gp       = 32'd56;
   localparam int page_offset_width_gp = 32'd12;
   localparam int pte_flag_width_gp    = 32'd7;
   localparam int perf_count_width_gp  = 32'd32;

   typedef enum logic [2:0] {
      e_ready     = 3'd0,
      e_lookup    = 3'd1,
      e_walk_req  = 3'd2,
      e_walk_wait = 3'd3,
      e_fence     = 3'd4
   } bp_tlb_ctrl_state_e;

   // Leaf PTE as held in the TLB: physical page tag plus permission flags.
   function automatic int bp_pte_leaf_width(input int paddr_width);
      return paddr_width - page_offset_width_gp + pte_flag_width_gp;
   endfunction

endpackage

// File: rtl/bp_tlb_ctrl_bsg.sv
// Basic storage blocks used by bp_tlb_ctrl: an enabled reset flop and a
// clearable up-counter, both with asynchronous active-high reset.
module bsg_dff_reset_en
   #(parameter int width_p = 32'd1)
   (input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
   );

   logic [width_p-1:0] data_r;

   // Holding register, loads only when enabled.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         data_r <= '0;
      end else if (en_i) begin
         data_r <= data_i;
      end else begin
         data_r <= data_r;
      end
   end

   assign data_o = data_r;

endmodule

module bsg_counter_clear_up
   #(parameter int width_p = 32'd32)
   (input  logic               clk_i,
    input  logic               reset_i,
    input  logic               clear_i,
    input  logic               up_i,
    output logic [width_p-1:0] count_o
   );

   logic [width_p-1:0] count_r;

   // Wrapping counter; clear takes precedence over increment.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         count_r <= '0;
      end else if (clear_i) begin
         count_r <= '0;
      end else if (up_i) begin
         count_r <= count_r + {{(width_p-1){1'b0}}, 1'b1};
      end else begin
         count_r <= count_r;
      end
   end

   assign count_o = count_r;

endmodule

// File: rtl/bp_tlb_ctrl.sv
// Lookup/miss/refill sequencer in front of a single-ported bp_tlb and a PTW.
// Define BP_TLB_CTRL_PERF_EN to build the hit/miss performance counters.
module bp_tlb_ctrl
   import bp_tlb_ctrl_pkg::*;
   #(parameter  int vtag_width_p   = vtag_width_gp,
     parameter  int paddr_width_p  = paddr_width_gp,
     localparam int entry_width_lp = bp_pte_leaf_width(paddr_width_p))
   (input  logic                      clk_i,
    input  logic                      reset_i,

    input  logic                      req_v_i,
    output logic                      req_ready_and_o,
    input  logic [vtag_width_p-1:0]   req_vtag_i,

    output logic                      resp_v_o,
    output logic [entry_width_lp-1:0] resp_entry_o,
    output logic                      resp_fault_o,

    input  logic                      fence_v_i,
    output logic                      fence_ready_and_o,

    output logic                      tlb_v_o,
    output logic                      tlb_w_o,
    output logic                      tlb_fence_o,
    output logic [vtag_width_p-1:0]   tlb_vtag_o,
    output logic [entry_width_lp-1:0] tlb_entry_o,
    input  logic                      tlb_v_i,
    input  logic [entry_width_lp-1:0] tlb_entry_i,

    output logic                      ptw_v_o,
    input  logic                      ptw_ready_and_i,
    output logic [vtag_width_p-1:0]   ptw_vtag_o,
    input  logic                      ptw_fill_v_i,
    input  logic [entry_width_lp-1:0] ptw_fill_entry_i,
    input  logic                      ptw_fill_fault_i,

    output logic [31:0]               hit_count_o,
    output logic [31:0]               miss_count_o
   );

   bp_tlb_ctrl_state_e state_r, state_n;

   logic [vtag_width_p-1:0] vtag_r;
   logic                    replay_r;
   logic                    replay_set_s;
   logic                    replay_en_s;
   logic                    req_accept_s;
   logic                    fence_accept_s;

   // State register.
   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_r <= e_ready;
      end else begin
         state_r <= state_n;
      end
   end

   // Ready generation: a fence wins over a request in e_ready, and only a
   // hit in e_lookup frees the TLB port for a back-to-back request.
   always_comb begin
      req_ready_and_o   = 1'b0;
      fence_ready_and_o = 1'b0;
      case (state_r)
         e_ready: begin
            fence_ready_and_o = 1'b1;
            req_ready_and_o   = ~fence_v_i;
         end
         e_lookup: begin
            req_ready_and_o = tlb_v_i;
         end
         default: begin
            req_ready_and_o   = 1'b0;
            fence_ready_and_o = 1'b0;
         end
      endcase
   end

   assign req_accept_s   = req_v_i & req_ready_and_o;
   assign fence_accept_s = fence_v_i & fence_ready_and_o;

   // Next-state logic.
   always_comb begin
      state_n = state_r;
      case (state_r)
         e_ready: begin
            if (fence_accept_s) begin
               state_n = e_fence;
            end else if (req_accept_s) begin
               state_n = e_lookup;
            end else begin
               state_n = e_ready;
            end
         end
         e_lookup: begin
            if (tlb_v_i) begin
               state_n = req_accept_s ? e_lookup : e_ready;
            end else begin
               state_n = replay_r ? e_ready : e_walk_req;
            end
         end
         e_walk_req: begin
            state_n = ptw_ready_and_i ? e_walk_wait : e_walk_req;
         end
         e_walk_wait: begin
            if (ptw_fill_v_i) begin
               state_n = ptw_fill_fault_i ? e_ready : e_lookup;
            end else begin
               state_n = e_walk_wait;
            end
         end
         e_fence: begin
            state_n = e_ready;
         end
         default: begin
            state_n = e_ready;
         end
      endcase
   end

   // Output decode for the requester, TLB port and PTW.
   always_comb begin
      tlb_v_o      = 1'b0;
      tlb_w_o      = 1'b0;
      tlb_fence_o  = 1'b0;
      tlb_vtag_o   = '0;
      tlb_entry_o  = '0;
      resp_v_o     = 1'b0;
      resp_entry_o = '0;
      resp_fault_o = 1'b0;
      ptw_v_o      = 1'b0;
      ptw_vtag_o   = '0;
      replay_set_s = 1'b0;
      case (state_r)
         e_ready: begin
            tlb_v_o    = req_accept_s;
            tlb_vtag_o = req_accept_s ? req_vtag_i : '0;
         end
         e_lookup: begin
            if (tlb_v_i) begin
               resp_v_o     = 1'b1;
               resp_entry_o = tlb_entry_i;
               tlb_v_o      = req_accept_s;
               tlb_vtag_o   = req_accept_s ? req_vtag_i : '0;
            end else begin
               // A miss after refill means the written entry did not stick.
               resp_v_o     = replay_r;
               resp_fault_o = replay_r;
            end
         end
         e_walk_req: begin
            ptw_v_o    = 1'b1;
            ptw_vtag_o = vtag_r;
         end
         e_walk_wait: begin
            if (ptw_fill_v_i & ptw_fill_fault_i) begin
               resp_v_o     = 1'b1;
               resp_fault_o = 1'b1;
            end else if (ptw_fill_v_i) begin
               tlb_v_o      = 1'b1;
               tlb_w_o      = 1'b1;
               tlb_vtag_o   = vtag_r;
               tlb_entry_o  = ptw_fill_entry_i;
               replay_set_s = 1'b1;
            end else begin
               resp_v_o = 1'b0;
            end
         end
         e_fence: begin
            tlb_fence_o = 1'b1;
         end
         default: begin
            tlb_v_o = 1'b0;
         end
      endcase
   end

   bsg_dff_reset_en #(.width_p(vtag_width_p)) vtag_reg
      (.clk_i   (clk_i),
       .reset_i (reset_i),
       .en_i    (req_accept_s),
       .data_i  (req_vtag_i),
       .data_o  (vtag_r)
      );

   assign replay_en_s = replay_set_s | resp_v_o;

   bsg_dff_reset_en #(.width_p(32'd1)) replay_reg
      (.clk_i   (clk_i),
       .reset_i (reset_i),
       .en_i    (replay_en_s),
       .data_i  (replay_set_s),
       .data_o  (replay_r)
      );

`ifdef BP_TLB_CTRL_PERF_EN
   logic hit_inc_s;
   logic miss_inc_s;

   // Replay lookups are part of a miss, so they count neither as hits nor misses.
   assign hit_inc_s  = (state_r == e_lookup) & tlb_v_i & ~replay_r;
   assign miss_inc_s = (state_r == e_lookup) & ~tlb_v_i & ~replay_r;

   bsg_counter_clear_up #(.width_p(perf_count_width_gp)) hit_counter
      (.clk_i   (clk_i),
       .reset_i (reset_i),
       .clear_i (1'b0),
       .up_i    (hit_inc_s),
       .count_o (hit_count_o)
      );

   bsg_counter_clear_up #(.width_p(perf_count_width_gp)) miss_counter
      (.clk_i   (clk_i),
       .reset_i (reset_i),
       .clear_i (1'b0),
       .up_i    (miss_inc_s),
       .count_o (miss_count_o)
      );
`else
   assign hit_count_o  = 32'd0;
   assign miss_count_o = 32'd0;
`endif

endmodule

// File: tb/tb_bp_tlb_ctrl.sv
// Directed bench for bp_tlb_ctrl: responses are scored against a queue of
// expected entries pushed when the matching stimulus is driven.
module tb_bp_tlb_ctrl;
   import bp_tlb_ctrl_pkg::*;

   localparam int vw = vtag_width_gp;
   localparam int ew = bp_pte_leaf_width(paddr_width_gp);
`ifdef BP_TLB_CTRL_PERF_EN
   localparam bit perf_lp = 1'b1;
`else
   localparam bit perf_lp = 1'b0;
`endif

   typedef struct {
      logic [63:0] entry;
      logic        fault;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          req_v, req_ready, resp_v, resp_fault;
   logic [vw-1:0] req_vtag, tlb_vtag, ptw_vtag;
   logic [ew-1:0] resp_entry, tlb_entry_o, tlb_entry_i, fill_entry;
   logic          fence_v, fence_ready, tlb_v_o, tlb_w, tlb_fence, tlb_v_i;
   logic          ptw_v, ptw_ready, fill_v, fill_fault;
   logic [31:0]   hit_count, miss_count;

   int   checks   = 0;
   int   failures = 0;
   exp_t sb_q[$];

   always #5 clk = ~clk;

   bp_tlb_ctrl dut
      (.clk_i             (clk),
       .reset_i           (reset),
       .req_v_i           (req_v),
       .req_ready_and_o   (req_ready),
       .req_vtag_i        (req_vtag),
       .resp_v_o          (resp_v),
       .resp_entry_o      (resp_entry),
       .resp_fault_o      (resp_fault),
       .fence_v_i         (fence_v),
       .fence_ready_and_o (fence_ready),
       .tlb_v_o           (tlb_v_o),
       .tlb_w_o           (tlb_w),
       .tlb_fence_o       (tlb_fence),
       .tlb_vtag_o        (tlb_vtag),
       .tlb_entry_o       (tlb_entry_o),
       .tlb_v_i           (tlb_v_i),
       .tlb_entry_i       (tlb_entry_i),
       .ptw_v_o           (ptw_v),
       .ptw_ready_and_i   (ptw_ready),
       .ptw_vtag_o        (ptw_vtag),
       .ptw_fill_v_i      (fill_v),
       .ptw_fill_entry_i  (fill_entry),
       .ptw_fill_fault_i  (fill_fault),
       .hit_count_o       (hit_count),
       .miss_count_o      (miss_count)
      );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic push(input logic [63:0] entry, input logic fault);
      exp_t e;
      e.entry = entry;
      e.fault = fault;
      sb_q.push_back(e);
   endtask

   task automatic chk_counts(input int hits, input int misses);
      chk("hit_count", hit_count, perf_lp ? hits : 0);
      chk("miss_count", miss_count, perf_lp ? misses : 0);
   endtask

   // Response scoreboard.
   always @(negedge clk) begin
      if (!reset && resp_v) begin
         exp_t e;
         chk("resp_expected", (sb_q.size() > 0), 1'b1);
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("resp_entry", resp_entry, e.entry);
            chk("resp_fault", resp_fault, e.fault);
         end
      end
   end

   initial begin
      reset = 1'b1; req_v = 1'b0; req_vtag = '0; fence_v = 1'b0;
      tlb_v_i = 1'b0; tlb_entry_i = '0; ptw_ready = 1'b0;
      fill_v = 1'b0; fill_entry = '0; fill_fault = 1'b0;
      repeat (2) @(posedge clk);
      smp();
      chk("rst_req_ready", req_ready, 1'b1);
      chk("rst_fence_ready", fence_ready, 1'b1);
      chk("rst_resp_v", resp_v, 1'b0);
      chk("rst_tlb_v", tlb_v_o, 1'b0);
      chk("rst_ptw_v", ptw_v, 1'b0);
      chk_counts(0, 0);
      cyc(); reset = 1'b0;

      // Single hit.
      cyc(); req_v = 1'b1; req_vtag = vw'(27'h12345); push(64'hABC, 1'b0);
      smp(); chk("hit_tlb_v", tlb_v_o, 1'b1); chk("hit_tlb_w", tlb_w, 1'b0);
      chk("hit_tlb_vtag", tlb_vtag, 64'h12345);
      cyc(); req_v = 1'b0; tlb_v_i = 1'b1; tlb_entry_i = ew'(64'hABC);
      smp(); chk("hit_resp_v", resp_v, 1'b1);
      cyc(); tlb_v_i = 1'b0;
      smp(); chk("hit_done_resp_v", resp_v, 1'b0); chk_counts(1, 0);

      // Three back-to-back hits.
      for (int i = 0; i < 4; i++) begin
         cyc();
         req_v = (i < 3); req_vtag = vw'(i + 1);
         tlb_v_i = (i > 0); tlb_entry_i = ew'(64'h100 + i);
         if (i < 3) push(64'h101 + i, 1'b0);
         smp();
         chk("b2b_req_ready", req_ready, 1'b1);
         chk("b2b_tlb_v", tlb_v_o, (i < 3));
         if (i > 0) chk("b2b_resp_v", resp_v, 1'b1);
         if (i < 3) chk("b2b_tlb_vtag", tlb_vtag, i + 1);
      end
      cyc(); tlb_v_i = 1'b0;
      smp(); chk_counts(4, 0);

      // Miss with a stalled PTW, then refill and replay.
      cyc(); req_v = 1'b1; req_vtag = vw'(27'h40);
      cyc(); req_v = 1'b0;
      smp(); chk("miss_resp_v", resp_v, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cyc(); ptw_ready = (i == 3);
         smp(); chk("walk_ptw_v", ptw_v, 1'b1); chk("walk_ptw_vtag", ptw_vtag, 64'h40);
      end
      cyc(); ptw_ready = 1'b0;
      smp(); chk("wait_ptw_v", ptw_v, 1'b0);
      cyc(); fill_v = 1'b1; fill_entry = ew'(64'h777); push(64'h777, 1'b0);
      smp(); chk("fill_tlb_v", tlb_v_o, 1'b1); chk("fill_tlb_w", tlb_w, 1'b1);
      chk("fill_tlb_vtag", tlb_vtag, 64'h40); chk("fill_tlb_entry", tlb_entry_o, 64'h777);
      chk("fill_resp_v", resp_v, 1'b0);
      cyc(); fill_v = 1'b0; tlb_v_i = 1'b1; tlb_entry_i = ew'(64'h777);
      smp(); chk("replay_resp_v", resp_v, 1'b1);
      cyc(); tlb_v_i = 1'b0;
      smp(); chk("replay_done_ready", req_ready, 1'b1); chk_counts(4, 1);

      // Miss, walk faults.
      cyc(); req_v = 1'b1; req_vtag = vw'(27'h55);
      cyc(); req_v = 1'b0;
      cyc(); ptw_ready = 1'b1;
      cyc(); ptw_ready = 1'b0; fill_v = 1'b1; fill_fault = 1'b1;
      fill_entry = ew'(64'h999); push(64'h0, 1'b1);
      smp(); chk("fault_tlb_v", tlb_v_o, 1'b0); chk("fault_resp_v", resp_v, 1'b1);
      cyc(); fill_v = 1'b0; fill_fault = 1'b0;
      smp(); chk("fault_done_ready", req_ready, 1'b1); chk_counts(4, 2);

      // Refill whose replay still misses.
      cyc(); req_v = 1'b1; req_vtag = vw'(27'h5A);
      cyc(); req_v = 1'b0;
      cyc(); ptw_ready = 1'b1;
      cyc(); ptw_ready = 1'b0; fill_v = 1'b1; fill_entry = ew'(64'h5A5);
      cyc(); fill_v = 1'b0; push(64'h0, 1'b1);
      smp(); chk("replay_miss_resp_v", resp_v, 1'b1);
      cyc();
      smp(); chk("replay_miss_ready", req_ready, 1'b1); chk_counts(4, 3);

      // Fence and request together: fence wins, request follows 2 cycles later.
      cyc(); fence_v = 1'b1; req_v = 1'b1; req_vtag = vw'(27'h66);
      smp(); chk("fence_ready", fence_ready, 1'b1); chk("fence_req_ready", req_ready, 1'b0);
      chk("fence_tlb_v", tlb_v_o, 1'b0);
      cyc(); fence_v = 1'b0;
      smp(); chk("fence_pulse", tlb_fence, 1'b1); chk("fence_busy_ready", req_ready, 1'b0);
      cyc(); push(64'h660, 1'b0);
      smp(); chk("fence_pulse_end", tlb_fence, 1'b0); chk("post_fence_tlb_v", tlb_v_o, 1'b1);
      chk("post_fence_vtag", tlb_vtag, 64'h66);
      cyc(); req_v = 1'b0; tlb_v_i = 1'b1; tlb_entry_i = ew'(64'h660); fence_v = 1'b1;
      smp(); chk("lookup_fence_ready", fence_ready, 1'b0);
      cyc(); tlb_v_i = 1'b0; fence_v = 1'b0;
      smp(); chk("lookup_no_fence", tlb_fence, 1'b0); chk_counts(5, 3);

      // Reset while waiting on the walk; the late fill must be dropped.
      cyc(); req_v = 1'b1; req_vtag = vw'(27'h77);
      cyc(); req_v = 1'b0;
      cyc(); ptw_ready = 1'b1;
      cyc(); ptw_ready = 1'b0; reset = 1'b1;
      smp(); chk("midrst_req_ready", req_ready, 1'b1); chk("midrst_ptw_v", ptw_v, 1'b0);
      chk_counts(0, 0);
      cyc(); reset = 1'b0;
      cyc(); fill_v = 1'b1; fill_entry = ew'(64'h888);
      smp(); chk("late_fill_tlb_v", tlb_v_o, 1'b0); chk("late_fill_resp_v", resp_v, 1'b0);
      chk("late_fill_ready", req_ready, 1'b1);
      cyc(); fill_v = 1'b0;
      smp(); chk("late_fill_idle", fence_ready, 1'b1);

      cyc();
      chk("sb_empty", sb_q.size(), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bp_tlb_ctrl.md
# bp_tlb_ctrl

Sequencer in front of one bp_tlb instance: accepts translation lookups from a single requester, drives the TLB's single read/write port, detects misses, issues a walk request to the page-table walker, and writes the returned leaf PTE back into the TLB. A write also performs a lookup, so the refill replays the translation. Also serialises fences (sfence.vma) against in-flight lookups and walks. Sits between the I- or D-side translation stage and bp_tlb + PTW.

## Interface
- bp_params_p, e_bp_default_cfg, processor config; supplies vtag_width_p, paddr_width_p
- entry_width_lp (local), `bp_pte_leaf_width(paddr_width_p)`, leaf PTE width
- clk_i  in  1  clock
- reset_i  in  1  reset; **asynchronous, active-high**
- req_v_i / req_ready_and_o  in/out  1  lookup handshake
- req_vtag_i  in  vtag_width_p  virtual tag
- resp_v_o  out  1  one-cycle response strobe; no backpressure
- resp_entry_o  out  entry_width_lp  translated leaf PTE
- resp_fault_o  out  1  walk returned a fault, or the replay missed
- fence_v_i / fence_ready_and_o  in/out  1  fence handshake
- tlb_v_o, tlb_w_o, tlb_fence_o  out  1  TLB port controls
- tlb_vtag_o  out  vtag_width_p;  tlb_entry_o  out  entry_width_lp  TLB write data
- tlb_v_i  in  1;  tlb_entry_i  in  entry_width_lp  TLB lookup result, valid one cycle after tlb_v_o
- ptw_v_o / ptw_ready_and_i  out/in  1  walk request handshake;  ptw_vtag_o  out  vtag_width_p
- ptw_fill_v_i  in  1;  ptw_fill_entry_i  in  entry_width_lp;  ptw_fill_fault_i  in  1  walk result
- hit_count_o, miss_count_o  out  32  performance counters (see Configuration)

## Operation
- States: e_ready, e_lookup, e_walk_req, e_walk_wait, e_fence.
- e_ready:
  - fence_ready_and_o=1. fence_v_i has priority over req_v_i in the same cycle. A fence -> e_fence.
  - Otherwise req_ready_and_o=1. An accepted request drives tlb_v_o=1, tlb_w_o=0, tlb_vtag_o=req_vtag_i, captures vtag_r, and goes to e_lookup.
- e_lookup, tlb_v_i=1 (hit):
  - resp_v_o=1, resp_entry_o=tlb_entry_i, resp_fault_o=0.
  - req_ready_and_o=1 in this state, so a back-to-back request issues to the TLB in the same cycle and the state stays e_lookup. Otherwise -> e_ready.
  - fence_v_i is not accepted here.
- e_lookup, tlb_v_i=0 (miss):
  - First miss -> e_walk_req.
  - Miss on a replay: resp_v_o=1, resp_fault_o=1 -> e_ready.
- e_walk_req: ptw_v_o=1, ptw_vtag_o=vtag_r. On ptw_ready_and_i -> e_walk_wait.
- e_walk_wait, on ptw_fill_v_i:
  - Fault: resp_v_o=1, resp_fault_o=1, resp_entry_o=0 -> e_ready.
  - Otherwise: tlb_v_o=1, tlb_w_o=1, tlb_vtag_o=vtag_r, tlb_entry_o=ptw_fill_entry_i, set the replay flag -> e_lookup.
- e_fence: tlb_fence_o=1 for exactly one cycle -> e_ready.
- ptw_fill_v_i is ignored outside e_walk_wait.
- The replay flag clears on any response.

## Timing
- Reset values: state=e_ready, every output 0 except req_ready_and_o=1 and fence_ready_and_o=1, counters=0, replay flag=0.
- Reset mid-walk abandons the walk. A late ptw_fill_v_i is dropped.
- Hit latency: request accept to resp_v_o is 1 cycle. Hit throughput: 1 per cycle.
- Miss latency: 1 (lookup) + PTW handshake + walk + 1 (fill/replay) cycles.
- Fence: accept to tlb_fence_o is 1 cycle. Next request accepted 2 cycles after fence accept.
- The req and fence ready signals depend combinationally on tlb_v_i only in e_lookup. No ready depends on its own valid.

## Configuration
- `BP_TLB_CTRL_PERF_EN` defined:
  - hit_count_o increments on each resp_v_o with a hit (replay hits excluded).
  - miss_count_o increments on each e_lookup -> e_walk_req transition.
  - Both are 32-bit and wrap modulo 2^32.
- Undefined: both ports are tied to 0 and no counter flops exist. The port list is unchanged.

## Structure
- bp_common_pkg: bp_tlb_ctrl_state_e enum.
- Widths come from the existing `declare_bp_proc_params` and `bp_pte_leaf_width` macros.
- One sub-module, bsg_counter_clear_up, instantiated twice for the counters under the macro.
- vtag_r and the replay flag use bsg_dff_reset_en.

## Test plan
- Reset released, req vtag 0x12345, TLB returns tlb_v_i=1, entry 0xABC -> resp_v_o next cycle with entry 0xABC. hit_count_o=1.
- Three back-to-back hits (vtags 0x1, 0x2, 0x3) -> three consecutive resp_v_o cycles, req_ready_and_o high throughout.
- Miss on 0x40, ptw_ready_and_i held low 3 cycles, then fill with entry 0x777 -> ptw_v_o held with vtag 0x40, tlb write of 0x777, replay hit, resp entry 0x777. miss_count_o=1.
- Miss, then fill with ptw_fill_fault_i=1 -> resp_v_o, resp_fault_o=1, no TLB write.
- fence_v_i and req_v_i asserted together in e_ready -> fence accepted, tlb_fence_o pulses 1 cycle, request accepted 2 cycles later.
- reset_i asserted in e_walk_wait, then ptw_fill_v_i after release -> no TLB write, no resp_v_o, state e_ready.
